frame_packer_eval: RTL and testbench
====================================

// Module: frame_packer_eval
// PURPOSE
//  Upstream feeder of the evaluation controller. Collects a stream of 6 complex samples into one packed frame.
//  Presents the frame on cur_data_real_o/imag_o, holds it until eval_busy_i is seen, then drives zero.
//  Waits for eval_done_i before presenting the next frame.
//  Downstream treats an all-zero real or imag bus as "no data", so this block never presents such a frame.
// PARAMETERS
//  p   22  integer/fraction bits per word; sample word width W = 3+p
//  pd  12  fractional-bit position, informational, no effect on logic
//  N   6   samples per frame, fixed by the downstream bus width (6*W); not overridable
// PORTS
//  clk_i            in   1    system clock, all state on rising edge
//  rst_n_i          in   1    asynchronous active-low reset
//  sample_real_i    in   W    real part of incoming sample
//  sample_imag_i    in   W    imag part of incoming sample
//  sample_valid_i   in   1    sample present this cycle
//  sample_ready_o   out  1    block can accept a sample; transfer = valid & ready
//  cur_data_real_o  out  6*W  packed frame, real parts
//  cur_data_imag_o  out  6*W  packed frame, imag parts
//  eval_busy_i      in   1    downstream has latched a frame and is evaluating
//  eval_done_i      in   1    downstream finished; level or pulse, sampled per clock
//  zero_frame_o     out  1    1-cycle pulse: completed frame dropped (all-zero real or imag)
//  frame_cnt_o      out  16   frames handed off since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 except sample_ready_o=1; state FILL; index=0.
//  Packing: k-th accepted sample of a frame (k=0..5) goes to bits [k*W +: W]; sample 0 at LSB.
//  FILL: each transfer writes the fill buffer at index and increments index.
//   Transfer at index 5 completes the frame; index returns to 0.
//   Completed frame checked: if real==0 or imag==0 -> pulse zero_frame_o, discard, stay in FILL.
//   Otherwise mark buffer full and go to PRESENT next cycle.
//  PRESENT: outputs = frame; sample_ready_o=0 (see EN).
//   Exit when eval_busy_i=1 at a clock edge: outputs -> 0 next cycle, frame_cnt_o++, go WAIT.
//  WAIT: outputs 0. On eval_done_i=1 with eval_busy_i=0 -> FILL.
//   If eval_busy_i and eval_done_i are both 1, busy wins and the block stays in WAIT.
//  Latency: last sample transfer at cycle t -> frame on outputs at t+1; cleared 1 cycle after busy seen.
//  eval_done_i seen in FILL or PRESENT is ignored (no underflow of state).
//  Async reset mid-frame discards partial frame and any buffered frame; no zero_frame_o pulse.
//  sample_valid_i=0 stalls filling indefinitely; index holds.
// CONFIGURATION
//  FRAME_PACKER_PINGPONG_EN defined: two frame buffers.
//   Filling of buffer B continues during PRESENT/WAIT of buffer A.
//   sample_ready_o=0 only when both buffers are full.
//   On WAIT->FILL with the other buffer full, go directly to PRESENT next cycle (zero-bubble handoff).
//  Undefined: single buffer; sample_ready_o=0 in PRESENT and WAIT; behaviour as above.
// STRUCTURE
//  Shared package/header: W=3+p, N=6, state encodings FILL=2'd0, PRESENT=2'd1, WAIT=2'd2, frame_cnt width 16.
//  One sub-module: frame_buf_eval (6xW real+imag buffer, indexed write, packed read, zero-detect flags).
//  Instantiated once, or twice under FRAME_PACKER_PINGPONG_EN.
// TESTING
//  Reset: rst_n_i=0 mid-frame after 3 samples -> outputs 0, ready=1; next 6 samples form a fresh frame.
//  Packing: real=1..6, imag=0x10..0x15 back-to-back -> cur_data_real_o word k = k+1, frame 1 cycle after 6th sample.
//  Zero drop: 6 samples with imag=0 -> zero_frame_o pulses once, outputs stay 0, frame_cnt_o unchanged.
//  Handoff: eval_busy_i=1 3 cycles after frame -> outputs 0 next cycle, frame_cnt_o=1; done+busy together holds WAIT.
//  Backpressure: no eval_done_i, 12 samples offered.
//   Single-buffer: ready low after 6th.
//   PINGPONG_EN: ready low after 12th; done -> second frame appears 1 cycle after WAIT exit.
//  Counter wrap: preload 0xFFFF via force, one handoff -> frame_cnt_o=0.

Source files
------------

// File: rtl/frame_packer_eval_pkg.sv
// Shared constants and state encoding for the frame packer.
// FRAME_PACKER_PINGPONG_EN selects two frame buffers instead of one.
package frame_packer_eval_pkg;

  localparam int P     = 22;
  localparam int PD    = 12;
  localparam int W     = 3 + P;
  localparam int N     = 6;
  localparam int FW    = N * W;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'(N - 1);

`ifdef FRAME_PACKER_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

endpackage

// File: rtl/frame_buf_eval.sv
// One frame store: N words of real+imag, indexed write, packed read.
// Zero flags look at the frame as it will be after this cycle's write.
module frame_buf_eval
  import frame_packer_eval_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [W-1:0]     wr_real_i,
  input  logic [W-1:0]     wr_imag_i,
  output logic [FW-1:0]    rd_real_o,
  output logic [FW-1:0]    rd_imag_o,
  output logic             nxt_real_zero_o,
  output logic             nxt_imag_zero_o
);

  logic [FW-1:0] nxt_real;
  logic [FW-1:0] nxt_imag;

  for (genvar gi = 0; gi < N; gi++) begin : g_word
    logic [W-1:0] real_q, real_d;
    logic [W-1:0] imag_q, imag_d;

    always_comb begin
      real_d = real_q;
      imag_d = imag_q;
      if (wr_en_i && (wr_idx_i == 3'(gi))) begin
        real_d = wr_real_i;
        imag_d = wr_imag_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        real_q <= '0;
        imag_q <= '0;
      end else begin
        real_q <= real_d;
        imag_q <= imag_d;
      end
    end

    assign rd_real_o[gi*W +: W] = real_q;
    assign rd_imag_o[gi*W +: W] = imag_q;
    assign nxt_real[gi*W +: W]  = real_d;
    assign nxt_imag[gi*W +: W]  = imag_d;
  end

  // Lets the caller judge a frame on the same cycle its last word arrives.
  assign nxt_real_zero_o = (nxt_real == '0);
  assign nxt_imag_zero_o = (nxt_imag == '0);

endmodule

// File: rtl/frame_packer_eval.sv
// Packs N complex samples into one frame and hands it to the evaluation controller.
// Define FRAME_PACKER_PINGPONG_EN for double buffering with zero-bubble handoff.
module frame_packer_eval
  import frame_packer_eval_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [W-1:0]     sample_real_i,
  input  logic [W-1:0]     sample_imag_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  output logic [FW-1:0]    cur_data_real_o,
  output logic [FW-1:0]    cur_data_imag_o,
  input  logic             eval_busy_i,
  input  logic             eval_done_i,
  output logic             zero_frame_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         full_q, full_d;
  logic               fill_sel_q, fill_sel_d;
  logic               pres_sel_q, pres_sel_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               zero_frame_q, zero_frame_d;

  logic [FW-1:0]      rd_real [2];
  logic [FW-1:0]      rd_imag [2];
  logic [1:0]         real_zero;
  logic [1:0]         imag_zero;

  logic               xfer;
  logic               frame_last;
  logic               frame_is_zero;
  logic               frame_good;

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    if (gi < NBUF) begin : g_inst
      frame_buf_eval u_buf (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .wr_en_i         (xfer && (fill_sel_q == 1'(gi))),
        .wr_idx_i        (idx_q),
        .wr_real_i       (sample_real_i),
        .wr_imag_i       (sample_imag_i),
        .rd_real_o       (rd_real[gi]),
        .rd_imag_o       (rd_imag[gi]),
        .nxt_real_zero_o (real_zero[gi]),
        .nxt_imag_zero_o (imag_zero[gi])
      );
    end else begin : g_none
      assign rd_real[gi]   = '0;
      assign rd_imag[gi]   = '0;
      assign real_zero[gi] = 1'b1;
      assign imag_zero[gi] = 1'b1;
    end
  end

  assign sample_ready_o = ~full_q[fill_sel_q];
  assign xfer           = sample_valid_i & sample_ready_o;
  assign frame_last     = xfer && (idx_q == LAST_IDX);
  assign frame_is_zero  = real_zero[fill_sel_q] | imag_zero[fill_sel_q];
  assign frame_good     = frame_last & ~frame_is_zero;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    full_d       = full_q;
    fill_sel_d   = fill_sel_q;
    pres_sel_d   = pres_sel_q;
    frame_cnt_d  = frame_cnt_q;
    zero_frame_d = 1'b0;

    if (xfer) begin
      idx_d = frame_last ? '0 : idx_q + 3'd1;
    end
    if (frame_last && frame_is_zero) begin
      zero_frame_d = 1'b1;
    end
    if (frame_good) begin
      full_d[fill_sel_q] = 1'b1;
`ifdef FRAME_PACKER_PINGPONG_EN
      fill_sel_d = ~fill_sel_q;
`endif
    end

    case (state_q)
      ST_FILL: begin
        if (frame_good) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (eval_busy_i) begin
          state_d     = ST_WAIT;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_WAIT: begin
        // Busy dominates done so a lingering done level cannot skip a frame.
        if (eval_done_i && !eval_busy_i) begin
          full_d[pres_sel_q] = 1'b0;
          state_d            = ST_FILL;
`ifdef FRAME_PACKER_PINGPONG_EN
          pres_sel_d = ~pres_sel_q;
          if (full_q[~pres_sel_q] || frame_good) state_d = ST_PRESENT;
`endif
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      full_q       <= '0;
      fill_sel_q   <= 1'b0;
      pres_sel_q   <= 1'b0;
      frame_cnt_q  <= '0;
      zero_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      full_q       <= full_d;
      fill_sel_q   <= fill_sel_d;
      pres_sel_q   <= pres_sel_d;
      frame_cnt_q  <= frame_cnt_d;
      zero_frame_q <= zero_frame_d;
    end
  end

  assign cur_data_real_o = (state_q == ST_PRESENT) ? rd_real[pres_sel_q] : '0;
  assign cur_data_imag_o = (state_q == ST_PRESENT) ? rd_imag[pres_sel_q] : '0;
  assign zero_frame_o    = zero_frame_q;
  assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_frame_packer_eval.sv
// Self-checking bench for frame_packer_eval: frame-queue model plus directed literal checks.
module tb_frame_packer_eval;
  import frame_packer_eval_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     s_real = '0;
  logic [W-1:0]     s_imag = '0;
  logic             s_valid = 1'b0;
  logic             busy = 1'b0;
  logic             done = 1'b0;
  logic             sample_ready_o;
  logic [FW-1:0]    cur_data_real_o;
  logic [FW-1:0]    cur_data_imag_o;
  logic             zero_frame_o;
  logic [CNT_W-1:0] frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_packer_eval dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .sample_real_i   (s_real),
    .sample_imag_i   (s_imag),
    .sample_valid_i  (s_valid),
    .sample_ready_o  (sample_ready_o),
    .cur_data_real_o (cur_data_real_o),
    .cur_data_imag_o (cur_data_imag_o),
    .eval_busy_i     (busy),
    .eval_done_i     (done),
    .zero_frame_o    (zero_frame_o),
    .frame_cnt_o     (frame_cnt_o)
  );

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of completed frames; the head is shown until busy takes it,
  // then stays occupied until done releases it.
  logic [W-1:0]  m_pr [N];
  logic [W-1:0]  m_pi [N];
  int            m_n = 0;
  logic [FW-1:0] m_fr_q [$];
  logic [FW-1:0] m_fi_q [$];
  bit            m_handed = 1'b0;
  logic [15:0]   m_frames = '0;
  bit            m_zero = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0; m_fr_q.delete(); m_fi_q.delete();
        m_handed = 1'b0; m_frames = '0; m_zero = 1'b0;
      end else begin
        bit shown, rdy;
        logic [FW-1:0] fr, fi;
        shown  = (m_fr_q.size() > 0) && !m_handed;
        rdy    = m_fr_q.size() < NBUF;
        m_zero = 1'b0;
        if (shown && busy) begin
          m_handed = 1'b1;
          m_frames = m_frames + 16'd1;
        end else if (m_handed && done && !busy) begin
          void'(m_fr_q.pop_front());
          void'(m_fi_q.pop_front());
          m_handed = 1'b0;
        end
        if (s_valid && rdy) begin
          m_pr[m_n] = s_real;
          m_pi[m_n] = s_imag;
          m_n++;
          if (m_n == N) begin
            m_n = 0;
            for (int k = 0; k < N; k++) begin
              fr[k*W +: W] = m_pr[k];
              fi[k*W +: W] = m_pi[k];
            end
            if (fr == '0 || fi == '0) m_zero = 1'b1;
            else begin
              m_fr_q.push_back(fr);
              m_fi_q.push_back(fi);
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit shown;
        shown = (m_fr_q.size() > 0) && !m_handed;
        check("cur_real",   cur_data_real_o, shown ? m_fr_q[0] : '0);
        check("cur_imag",   cur_data_imag_o, shown ? m_fi_q[0] : '0);
        check("ready",      sample_ready_o,  (m_fr_q.size() < NBUF) ? 1'b1 : 1'b0);
        check("zero_frame", zero_frame_o,    m_zero);
        check("frame_cnt",  frame_cnt_o,     m_frames);
      end
    end
  end

  // All driver tasks start and end at a falling edge.
  task automatic put(input logic [W-1:0] r, input logic [W-1:0] i);
    int budget = 0;
    s_valid = 1'b1; s_real = r; s_imag = i;
    while (!sample_ready_o && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("ready_wait", sample_ready_o, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] rb, input logic [W-1:0] rs,
                            input logic [W-1:0] ib, input logic [W-1:0] is);
    for (int k = 0; k < N; k++) put(rb + W'(k) * rs, ib + W'(k) * is);
  endtask

  task automatic handoff();
    busy = 1'b1; @(negedge clk); busy = 1'b0;
    done = 1'b1; @(negedge clk); done = 1'b0;
  endtask

  logic [FW-1:0] exp_pk_r;
  logic [FW-1:0] exp_pk_i;
  logic [FW-1:0] exp_bp1;
  logic [FW-1:0] exp_bp2;
  int            n_xfer;
  int            n_zero;

  initial begin
    exp_pk_r = {25'd6, 25'd5, 25'd4, 25'd3, 25'd2, 25'd1};
    exp_pk_i = {25'h15, 25'h14, 25'h13, 25'h12, 25'h11, 25'h10};
    exp_bp1  = {25'h106, 25'h105, 25'h104, 25'h103, 25'h102, 25'h101};
    exp_bp2  = {25'h10c, 25'h10b, 25'h10a, 25'h109, 25'h108, 25'h107};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", sample_ready_o, 1'b1);
    check("rst_real", cur_data_real_o, '0);
    check("rst_cnt", frame_cnt_o, '0);

    // Reset mid-frame after 3 samples
    put(25'h7, 25'h8); put(25'h7, 25'h8); put(25'h7, 25'h8);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", sample_ready_o, 1'b1);
    check("midrst_real", cur_data_real_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Packing
    send_frame(25'd1, 25'd1, 25'h10, 25'd1);
    check("pack_real", cur_data_real_o, exp_pk_r);
    check("pack_imag", cur_data_imag_o, exp_pk_i);
    check("pack_ready", sample_ready_o, (NBUF > 1) ? 1'b1 : 1'b0);

    // Handoff, then busy+done together holds WAIT
    repeat (3) @(negedge clk);
    check("hold_real", cur_data_real_o, exp_pk_r);
    busy = 1'b1;
    @(negedge clk);
    check("handoff_real", cur_data_real_o, '0);
    check("handoff_cnt", frame_cnt_o, 16'd1);
    done = 1'b1;
    repeat (2) @(negedge clk);
    busy = 1'b0; done = 1'b0;
    @(negedge clk);
    check("busydone_ready", sample_ready_o, (NBUF > 1) ? 1'b1 : 1'b0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("wait_exit_ready", sample_ready_o, 1'b1);

    // Zero drop
    send_frame(25'd3, 25'd1, 25'd0, 25'd0);
    check("zero_pulse", zero_frame_o, 1'b1);
    n_zero = 1;
    @(negedge clk);
    if (zero_frame_o) n_zero++;
    check("zero_count", 32'(n_zero), 32'd1);
    check("zero_real", cur_data_real_o, '0);
    check("zero_cnt", frame_cnt_o, 16'd1);

    // Backpressure: 12 samples offered, no done
    n_xfer = 0;
    for (int c = 0; c < 12; c++) begin
      s_valid = 1'b1;
      s_real = 25'h101 + W'(n_xfer);
      s_imag = 25'h201 + W'(n_xfer);
      if (sample_ready_o) n_xfer++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("bp_xfers", 32'(n_xfer), 32'(6 * NBUF));
    check("bp_ready", sample_ready_o, 1'b0);
    check("bp_frame1", cur_data_real_o, exp_bp1);
    handoff();
`ifdef FRAME_PACKER_PINGPONG_EN
    check("bp_frame2", cur_data_real_o, exp_bp2);
    handoff();
`else
    check("bp_ready_after", sample_ready_o, 1'b1);
    check("bp_real_after", cur_data_real_o, '0);
`endif
    check("bp_cnt", frame_cnt_o, 16'(1 + NBUF));

    // Counter wrap
    #2 force dut.frame_cnt_q = 16'hFFFF;
    m_frames = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    send_frame(25'h40, 25'd2, 25'h50, 25'd3);
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    check("wrap_cnt", frame_cnt_o, 16'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
